// File: rtl/sink_arbiter.sv
// Round-robin sink arbiter: grants one ready node port at a time, pulses its
// read for one cycle and queues the captured value in a FIFO for a downstream
// consumer.
// Optional build macro: SINK_ARB_CLAMP_EN saturates captured values to
// [-999, 999] (signed) before they enter the FIFO.
module sink_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               rready,
  input  logic [N*W-1:0]             in,
  output logic [N-1:0]               read,
  output logic [$clog2(N)-1:0]       grant_id,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  input  logic                       out_read,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned NW  = $clog2(N);
  localparam int unsigned NW1 = NW + 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t         state, state_next;
  logic [NW-1:0]  ptr, ptr_next, grant_next;
  logic [N-1:0]   read_next;
  logic [CW-1:0]  count_next;
  logic [AW-1:0]  rd_idx, wr_idx, rd_idx_next, wr_idx_next;
  logic [W-1:0]   mem [DEPTH];

  logic [2*N-1:0] rr_dbl;
  logic [N-1:0]   rr_rot;
  logic [NW-1:0]  rr_off;
  logic [NW1-1:0] rr_sum, g_inc;
  logic [NW-1:0]  g_c, g_next_ptr_c;
  logic           push_c, pop_c;
  logic [W-1:0]   in_sel_c, push_data_c;

  // Rotate requests so bit 0 is the port at ptr, find the first set bit and map back
  always_comb begin
    rr_dbl = {rready, rready} >> ptr;
    rr_rot = rr_dbl[N-1:0];
    rr_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rr_rot[k]) rr_off = NW'(k);
    end
    rr_sum = {1'b0, ptr} + {1'b0, rr_off};
    if (rr_sum >= NW1'(N)) rr_sum = rr_sum - NW1'(N);
    g_c   = rr_sum[NW-1:0];
    g_inc = {1'b0, g_c} + NW1'(1);
    if (g_inc >= NW1'(N)) g_inc = '0;
    g_next_ptr_c = g_inc[NW-1:0];
  end

  // Select the granted port's data and optionally saturate it
  always_comb begin
    in_sel_c = '0;
    for (int k = 0; k < N; k++) begin
      if (g_c == NW'(k)) in_sel_c = in[k*W +: W];
    end
`ifdef SINK_ARB_CLAMP_EN
    if ($signed(in_sel_c) > $signed(W'(999)))
      push_data_c = W'(999);
    else if ($signed(in_sel_c) < $signed(W'(-999)))
      push_data_c = W'(-999);
    else
      push_data_c = in_sel_c;
`else
    push_data_c = in_sel_c;
`endif
  end

  // Next-state and register-input logic; grants only from IDLE with registered room
  always_comb begin
    state_next  = state;
    read_next   = '0;
    grant_next  = grant_id;
    ptr_next    = ptr;
    push_c      = 1'b0;
    case (state)
      IDLE: begin
        if ((count < CW'(DEPTH)) && (|rready)) begin
          push_c         = 1'b1;
          read_next[g_c] = 1'b1;
          grant_next     = g_c;
          ptr_next       = g_next_ptr_c;
          state_next     = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    pop_c       = out_read && (count != '0);
    count_next  = count + CW'(push_c) - CW'(pop_c);
    wr_idx_next = push_c ? wr_idx + 1'b1 : wr_idx;
    rd_idx_next = pop_c  ? rd_idx + 1'b1 : rd_idx;
  end

  // State and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      read      <= '0;
      grant_id  <= '0;
      ptr       <= '0;
      count     <= '0;
      rd_idx    <= '0;
      wr_idx    <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      read      <= read_next;
      grant_id  <= grant_next;
      ptr       <= ptr_next;
      count     <= count_next;
      rd_idx    <= rd_idx_next;
      wr_idx    <= wr_idx_next;
      out_valid <= (count_next != '0);
    end
  end

  // FIFO storage; contents are don't-care while count excludes them
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_idx] <= push_data_c;
  end

  assign out_data = (count != '0) ? mem[rd_idx] : '0;

endmodule

// File: tb/tb_sink_arbiter.sv
// Directed testbench for sink_arbiter (N=4, DEPTH=8, W=11).
module tb_sink_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned W     = 11;

  logic           clk;
  logic           rst;
  logic [N-1:0]   rready;
  logic [N*W-1:0] in_bus;
  logic [N-1:0]   read;
  logic [1:0]     grant_id;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_read;
  logic [3:0]     count;

  int tests;
  int failed;

  sink_arbiter #(.N(N), .DEPTH(DEPTH), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .rready   (rready),
    .in       (in_bus),
    .read     (read),
    .grant_id (grant_id),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_read (out_read),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned drain [8] = '{11, 12, 13, 10, 11, 12, 13, 10};
  logic [W-1:0] exp_hi, exp_lo;

  initial begin
    tests    = 0;
    failed   = 0;
    rst      = 1'b1;
    rready   = 4'b1111;
    out_read = 1'b0;
    in_bus   = '0;
    for (int i = 0; i < N; i++) in_bus[i*W +: W] = W'(10 + i);

    // Reset holds everything idle even with all ports ready
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_read", 32'(read), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
    end
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);

    // Round robin across all ports until the FIFO fills
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_read", 32'(read), 32'(1 << (k % 4)));
      check("rr_gid", 32'(grant_id), 32'(k % 4));
      check("rr_count", 32'(count), 32'(k + 1));
      step();
      check("rr_ack_read", 32'(read), 32'd0);
    end

    // Full: no grant while count==DEPTH
    step();
    check("full_read", 32'(read), 32'd0);
    check("full_count", 32'(count), 32'd8);
    check("full_head", 32'(out_data), 32'd10);
    out_read = 1'b1;
    step();
    out_read = 1'b0;
    check("full_pop_read", 32'(read), 32'd0);
    check("full_pop_count", 32'(count), 32'd7);
    check("full_pop_head", 32'(out_data), 32'd11);
    step();
    check("full_regrant_read", 32'(read), 32'b0001);
    check("full_regrant_count", 32'(count), 32'd8);
    rready = '0;

    // Drain in order, then an empty pop is ignored
    out_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_data", 32'(out_data), 32'(drain[k]));
      step();
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data0", 32'(out_data), 32'd0);
    step();
    check("underflow_count", 32'(count), 32'd0);
    out_read = 1'b0;

    // Simultaneous push and pop with a single entry
    in_bus[1*W +: W] = W'(5);
    rready = 4'b0010;
    step();
    check("sim_gid", 32'(grant_id), 32'd1);
    rready = '0;
    step();
    check("sim_count1", 32'(count), 32'd1);
    check("sim_head5", 32'(out_data), 32'd5);
    in_bus[2*W +: W] = W'(7);
    rready   = 4'b0100;
    out_read = 1'b1;
    step();
    rready   = '0;
    out_read = 1'b0;
    check("sim_read", 32'(read), 32'b0100);
    check("sim_count", 32'(count), 32'd1);
    check("sim_head7", 32'(out_data), 32'd7);
    step();
    out_read = 1'b1;
    step();
    out_read = 1'b0;
    check("sim_empty", 32'(count), 32'd0);

    // Capture of extreme values (saturated only in the clamp build)
`ifdef SINK_ARB_CLAMP_EN
    exp_hi = 11'h3E7;
    exp_lo = 11'h419;
`else
    exp_hi = 11'h3FF;
    exp_lo = 11'h400;
`endif
    in_bus[3*W +: W] = 11'h3FF;
    rready = 4'b1000;
    step();
    check("clamp_gid3", 32'(grant_id), 32'd3);
    rready = '0;
    step();
    in_bus[0*W +: W] = 11'h400;
    rready = 4'b0001;
    step();
    check("clamp_gid0", 32'(grant_id), 32'd0);
    rready = '0;
    step();
    check("clamp_count", 32'(count), 32'd2);
    check("clamp_hi", 32'(out_data), 32'(exp_hi));
    out_read = 1'b1;
    step();
    check("clamp_lo", 32'(out_data), 32'(exp_lo));
    step();
    out_read = 1'b0;
    check("clamp_empty", 32'(count), 32'd0);

    // Reset during ACK with three entries queued; pointer returns to port 0
    rready = 4'b0010;
    for (int k = 0; k < 5; k++) step();
    check("mid_count", 32'(count), 32'd3);
    check("mid_read", 32'(read), 32'b0010);
    rst = 1'b1;
    #1;
    check("mid_rst_read", 32'(read), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    step();
    rst    = 1'b0;
    rready = 4'b1111;
    step();
    check("mid_post_read", 32'(read), 32'b0001);
    check("mid_post_gid", 32'(grant_id), 32'd0);
    check("mid_post_count", 32'(count), 32'd1);
    rready = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
